// File: rtl/fc_argmax_collector_pkg.sv
// Shared types and constants for the argmax collector and its score buffer.
package fc_argmax_collector_pkg;

  localparam int IDX_W          = 8;
  localparam int CNT_W          = IDX_W + 1;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_NEURON_NUM = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_RESULT  = 2'd2
  } state_e;

endpackage

// File: rtl/fc_argmax_collector_score_buffer.sv
// Score buffer: DEPTH x DATA_W memory with one write port and a registered read port.
// Out-of-range addresses read as zero; memory contents are never reset.
module score_buffer
  import fc_argmax_collector_pkg::*;
#(
  parameter int DEPTH  = DEF_NEURON_NUM,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = DEPTH[CNT_W-1:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  logic              rd_in_range, wr_in_range;
  logic [AW-1:0]     rd_idx, wr_idx;

  assign rd_in_range = {1'b0, rd_addr} < DEPTH_C;
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_C;
  assign rd_idx      = rd_addr[AW-1:0];
  assign wr_idx      = wr_addr[AW-1:0];

  always_comb begin
    rd_data_d = '0;
    if (rd_in_range) begin
      rd_data_d = mem[rd_idx];
    end
  end

  // Storage is deliberately outside the reset domain so scores survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fc_argmax_collector.sv
// Streams one output vector of neuron values, tracks the first maximum and
// presents its index and value as a held result; values are kept in a score buffer.
module fc_argmax_collector
  import fc_argmax_collector_pkg::*;
#(
  parameter int NEURON_NUM = DEF_NEURON_NUM,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_index,
  input  logic              in_last,
  output logic              in_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDX_W-1:0]  res_class,
  output logic [DATA_W-1:0] res_score,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              seq_err
);

  localparam logic [CNT_W-1:0] LAST_COUNT = NEURON_NUM[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic signed [DATA_W-1:0]  max_q, max_d;
  logic [IDX_W-1:0]          class_q, class_d;
  logic                      seq_err_q, seq_err_d;

  logic                      accept;
  logic                      idx_in_range;
  logic                      idx_unexpected;
  logic                      closing;
  logic                      take_new;
  logic [CNT_W-1:0]          expected_idx;
  logic [CNT_W-1:0]          next_count;

  assign in_ready       = (state_q != ST_RESULT);
  assign accept         = in_valid && in_ready;
  assign expected_idx   = (state_q == ST_IDLE) ? '0 : count_q;
  assign next_count     = (state_q == ST_IDLE) ? CNT_ONE : count_q + CNT_ONE;
  assign idx_in_range   = {1'b0, in_index} < LAST_COUNT;
  assign idx_unexpected = {1'b0, in_index} != expected_idx;
  assign closing        = accept && (in_last || (next_count == LAST_COUNT));

  // Strict compare keeps the earliest index on ties; the first neuron always loads.
  assign take_new = (state_q == ST_IDLE) || ($signed(in_data) > max_q);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    max_d     = max_q;
    class_d   = class_q;
    seq_err_d = seq_err_q;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (accept) begin
          count_d = next_count;
          if (take_new) begin
            max_d   = $signed(in_data);
            class_d = in_index;
          end
          if (idx_unexpected || !idx_in_range) begin
            seq_err_d = 1'b1;
          end
          state_d = closing ? ST_RESULT : ST_COLLECT;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      max_q     <= '0;
      class_q   <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      max_q     <= max_d;
      class_q   <= class_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign res_valid = (state_q == ST_RESULT);
  assign res_class = class_q;
  assign res_score = max_q;
  assign seq_err   = seq_err_q;

  // Out-of-range indices still count toward the vector but are never stored.
  score_buffer #(
    .DEPTH  (NEURON_NUM),
    .DATA_W (DATA_W)
  ) u_score_buffer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept && idx_in_range),
    .wr_addr (in_index),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_fc_argmax_collector.sv
// Scoreboard bench for fc_argmax_collector: directed scenarios plus random vectors
// checked against a vector-level argmax model and a shadow copy of the score buffer.
module tb_fc_argmax_collector;

  localparam int NN = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [7:0]    in_index;
  logic          in_last;
  logic          in_ready;
  logic          res_valid;
  logic          res_ready;
  logic [7:0]    res_class;
  logic [DW-1:0] res_score;
  logic [7:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic          seq_err;

  typedef struct {
    int cls;
    int score;
    bit serr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rr_mode = 0;

  int   m_count = 0;
  int   m_max   = 0;
  int   m_cls   = 0;
  bit   m_serr  = 1'b0;
  int   m_buf   [256];
  bit   m_known [256];

  fc_argmax_collector #(
    .NEURON_NUM (NN),
    .DATA_W     (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_index  (in_index),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_class (res_class),
    .res_score (res_score),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Vector-level reference: a vector ends on last or after NN neurons; the
  // result is the index of the first strictly largest value.
  function automatic bit model_accept(int idx, int data, bit last);
    if (m_count == 0 || data > m_max) begin
      m_max = data;
      m_cls = idx;
    end
    if (idx != m_count || idx >= NN) m_serr = 1'b1;
    if (idx < NN) begin
      m_buf[idx]   = data;
      m_known[idx] = 1'b1;
    end
    m_count++;
    if (last || m_count == NN) begin
      exp_q.push_back('{m_cls, m_max, m_serr});
      m_count = 0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        1:       res_ready = 1'b0;
        2:       res_ready = 1'b1;
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got class %0d score %0d, expected no result", res_class, res_score);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("res_class", res_class, e.cls);
        checkOutput("res_score", res_score, e.score);
        checkOutput("seq_err_at_result", seq_err, e.serr);
      end
    end
  end

  // Drives one neuron until accepted; on a closing accept also checks 1-cycle latency.
  task automatic applyStimulus(input int idx, input int data, input bit last, output bit closed);
    int waited;
    closed = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_index = 8'(idx);
    in_data  = DW'(data);
    in_last  = last;
    waited   = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    closed   = model_accept(idx, data, last);
    if (closed) begin
      @(negedge clk);
      checkOutput("res_valid_latency", res_valid, 1);
    end
  endtask

  task automatic send_vector(input int idx[10], input int dat[10], input int len, input bit last_final);
    bit closed;
    for (int i = 0; i < len; i++) begin
      applyStimulus(idx[i], dat[i], last_final && (i == len - 1), closed);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m_count = 0;
    m_serr  = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || res_valid) checkOutput("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  idx[10];
    int  dat[10];
    int  d36[10] = '{3, 7, 2, 9, 9, 1, 0, 4, 5, 6};
    bit  closed;

    for (int i = 0; i < 256; i++) begin
      m_buf[i]   = 0;
      m_known[i] = 1'b0;
    end
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_index = '0; in_last = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_res_valid", res_valid, 0);
    checkOutput("reset_res_class", res_class, 0);
    checkOutput("reset_res_score", res_score, 0);
    checkOutput("reset_seq_err", seq_err, 0);
    checkOutput("reset_rd_data", rd_data, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1);

    // Scenario: 3,7,2,9,9,... with the result held for 20 cycles.
    rr_mode = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin idx[i] = i; dat[i] = d36[i]; end
    send_vector(idx, dat, 10, 1'b0);
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; in_index = 8'd0; in_data = 8'd77; in_last = 1'b1;
      @(negedge clk);
      checkOutput("hold_res_valid", res_valid, 1);
      checkOutput("hold_in_ready", in_ready, 0);
      checkOutput("hold_res_class", res_class, 3);
      checkOutput("hold_res_score", res_score, 9);
    end
    in_valid = 1'b0; in_last = 1'b0;
    rr_mode = 2;
    wait_idle();

    // res_ready already high: valid for exactly one cycle.
    for (int i = 0; i < 10; i++) begin idx[i] = i; dat[i] = 0; end
    send_vector(idx, dat, 10, 1'b0);
    @(negedge clk);
    checkOutput("one_cycle_valid", res_valid, 0);

    // in_last at index 4.
    for (int i = 0; i < 5; i++) idx[i] = i;
    dat[0] = 1; dat[1] = 2; dat[2] = 3; dat[3] = 8; dat[4] = 5;
    send_vector(idx, dat, 5, 1'b1);
    checkOutput("short_vec_seq_err", seq_err, 0);
    wait_idle();

    // in_last on the first neuron gives a one-neuron result.
    applyStimulus(0, 42, 1'b1, closed);
    wait_idle();

    // Reset mid-vector, then a full vector 10..19.
    for (int i = 0; i < 10; i++) begin idx[i] = i; dat[i] = 100 + i; end
    send_vector(idx, dat, 5, 1'b0);
    do_reset();
    checkOutput("midreset_res_valid", res_valid, 0);
    checkOutput("midreset_in_ready", in_ready, 1);
    for (int i = 0; i < 10; i++) begin idx[i] = i; dat[i] = 10 + i; end
    send_vector(idx, dat, 10, 1'b0);
    wait_idle();
    rd_addr = 8'd2;
    @(negedge clk);
    checkOutput("rd_addr2", rd_data, 12);

    // Reset while a result is pending discards it.
    rr_mode = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin idx[i] = i; dat[i] = 20 + i; end
    send_vector(idx, dat, 10, 1'b0);
    do_reset();
    checkOutput("result_reset_res_valid", res_valid, 0);
    checkOutput("result_reset_in_ready", in_ready, 1);
    rr_mode = 2;

    // Index sequence 0,1,3 sets the sticky error.
    idx[0] = 0; idx[1] = 1; idx[2] = 3;
    dat[0] = 5; dat[1] = 6; dat[2] = 7;
    send_vector(idx, dat, 3, 1'b1);
    checkOutput("seq_err_set", seq_err, 1);
    wait_idle();

    // Random vectors with random backpressure, ties and occasional bad indices.
    rr_mode = 0;
    for (int v = 0; v < 40; v++) begin
      int len;
      len = int'($urandom_range(1, 10));
      for (int i = 0; i < len; i++) begin
        int  ix;
        int  dv;
        bit  last;
        ix = i;
        dv = int'($urandom_range(0, 15));
        if ($urandom_range(0, 15) == 0) begin
          ix = (i == 0) ? int'($urandom_range(0, NN - 1)) : int'($urandom_range(0, NN + 2));
          if (ix >= NN) dv = 0;
        end
        last = (i == len - 1) && (len < NN || $urandom_range(0, 1) == 1);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        applyStimulus(ix, dv, last, closed);
      end
    end
    rr_mode = 2;
    wait_idle();
    checkOutput("seq_err_sticky", seq_err, 1);

    for (int a = 0; a < NN + 2; a++) begin
      rd_addr = 8'(a);
      @(negedge clk);
      if (a >= NN) checkOutput("rd_out_of_range", rd_data, 0);
      else if (m_known[a]) checkOutput("rd_buffer", rd_data, m_buf[a]);
    end

    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("final_reset_seq_err", seq_err, 0);
    checkOutput("final_reset_rd_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fc_argmax_collector.md
FC_ARGMAX_COLLECTOR -- requirements
Module: fc_argmax_collector

Interface
REQ-001 The block SHALL have parameter NEURON_NUM, default 10, meaning neurons per output vector (1..256).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning width of each signed neuron value.
REQ-003 The block SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-004 The block SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  neuron value present this cycle.
REQ-006 The block SHALL have port in_data  input  DATA_W  signed post-ReLU neuron value.
REQ-007 The block SHALL have port in_index  input  8  neuron number of in_data.
REQ-008 The block SHALL have port in_last  input  1  final neuron of the vector.
REQ-009 The block SHALL have port in_ready  output  1  block accepts a neuron this cycle.
REQ-010 The block SHALL have port res_valid  output  1  classification result held.
REQ-011 The block SHALL have port res_ready  input  1  downstream takes the result.
REQ-012 The block SHALL have port res_class  output  8  index of the maximum neuron.
REQ-013 The block SHALL have port res_score  output  DATA_W  value of the maximum neuron.
REQ-014 The block SHALL have port rd_addr  input  8  score buffer read address.
REQ-015 The block SHALL have port rd_data  output  DATA_W  buffered score at rd_addr, registered with 1-cycle latency.
REQ-016 The block SHALL have port seq_err  output  1  sticky sequence error flag.

Function
REQ-017 The FSM SHALL have three states: IDLE, COLLECT and RESULT.
REQ-018 An input SHALL be accepted only on a cycle where in_valid and in_ready are both high; in_ready SHALL be high in IDLE and COLLECT and low in RESULT.
REQ-019 An accept in IDLE SHALL move the FSM to COLLECT, load the running max with in_data, set the class to in_index, set the count to 1, and write the buffer.
REQ-020 Each accept SHALL write in_data to buffer[in_index] in the same cycle.
REQ-021 An accept in COLLECT SHALL replace the max and class only when in_data > max (signed, strict), so ties keep the lowest index.
REQ-022 The vector SHALL close on an accept with in_last=1, or on the accept that brings the count to NEURON_NUM, whichever comes first; the FSM SHALL then enter RESULT the next cycle with res_valid=1.
REQ-023 res_class and res_score SHALL include the closing neuron, so latency is 1 cycle from the last accept to res_valid.
REQ-024 res_valid, res_class and res_score SHALL remain stable until res_valid and res_ready are both high.
REQ-025 The FSM SHALL then return to IDLE on the next cycle with res_valid=0; the buffer contents SHALL be retained.
REQ-026 When res_ready is already high on entry to RESULT, the result SHALL stay valid for exactly one cycle.
REQ-027 seq_err SHALL be set when an accepted in_index differs from the expected count, or is >= NEURON_NUM; the datum SHALL still be counted but SHALL NOT be written to the buffer if it is out of range.
REQ-028 seq_err SHALL clear only on reset.
REQ-029 An in_last in IDLE SHALL produce a one-neuron result.
REQ-030 rd_addr >= NEURON_NUM SHALL return 0.

Reset
REQ-031 On rst, the FSM SHALL go to IDLE and the count, max, res_class, res_score, res_valid, seq_err and rd_data SHALL go to 0; in_ready SHALL go to 1 after reset is released.
REQ-032 Buffer contents SHALL NOT be reset.
REQ-033 Reset asserted mid-vector or in RESULT SHALL discard the partial or pending result.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the index width constant (8) and the default DATA_W and NEURON_NUM.
REQ-035 One sub-module, score_buffer, SHALL implement the NEURON_NUM x DATA_W single-write, registered-read memory; the compare and FSM logic SHALL stay in the top.

Verification
REQ-036 Scenario: NEURON_NUM=10, data 3,7,2,9,9,1,0,4,5,6 at indices 0..9 -> res_class=3, res_score=9 one cycle after index 9; the tie at index 4 is not taken.
REQ-037 Scenario: all ten values 0 -> res_class=0, res_score=0.
REQ-038 Scenario: in_last on index 4 with data 1,2,3,8,5 -> result after 5 accepts: res_class=3, res_score=8; seq_err=0.
REQ-039 Scenario: res_ready held low for 20 cycles -> res_valid and outputs stable, in_ready=0, in_valid ignored, no buffer write.
REQ-040 Scenario: index sequence 0,1,3 -> seq_err=1 after the third accept and it persists across later vectors until rst.
REQ-041 Scenario: rst pulsed after 5 accepts, then a full vector 10..19 -> res_class=9, res_score=19; rd_addr=2 returns 12 one cycle later.
